// File: rtl/pwm_pkg.sv
// Shared constants and the saturating duty-step helper for the PWM generators.
package pwm_pkg;

    localparam int CNT_W_DEF     = 8;
    localparam int PERIOD_DEF    = 100;
    localparam int DUTY_INIT_DEF = 50;

    // One up or down step, clamped to [0, lim]; opposing requests cancel.
    function automatic int sat_add_sub(input int v, input logic up, input logic dn,
                                       input int step, input int lim);
        if (up && !dn) begin
            return (v + step > lim) ? lim : v + step;
        end
        if (dn && !up) begin
            return (v < step) ? 0 : v - step;
        end
        return v;
    endfunction

endpackage

// File: rtl/pwm_presc_tick.sv
// Free-running 7-bit divider producing a one-cycle clock-enable every 2^conf clocks.
module pwm_presc_tick (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] conf,
    output logic       tick
);

    logic [6:0] div;
    logic [6:0] mask;

    // conf is compared live, so a new width takes hold at its next all-ones point.
    assign mask = 7'((8'd1 << conf) - 8'd1);
    assign tick = ((div & mask) == mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else begin
            div <= div + 7'd1;
        end
    end

endmodule

// File: rtl/pwm_multi_gen.sv
// N_CH-channel PWM generator sharing one prescaler tick and period counter.
// Optional PWM_PHASE_STAGGER_EN: channel k compares against (cnt + k*PERIOD/N_CH) mod PERIOD.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int PERIOD    = PERIOD_DEF,
    parameter int STEP      = 1,
    parameter int DUTY_INIT = DUTY_INIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [2:0]            conf,
    input  logic [N_CH-1:0]       xu,
    input  logic [N_CH-1:0]       xd,
    output logic [N_CH*CNT_W-1:0] duty,
    output logic [N_CH-1:0]       pwm
);

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DINIT = CNT_W'(DUTY_INIT);

    logic             tick;
    logic             wrap;
    logic [CNT_W-1:0] cnt;

    pwm_presc_tick u_presc (
        .clk  (clk),
        .rst  (rst),
        .conf (conf),
        .tick (tick)
    );

    assign wrap = tick && ena && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!ena) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic             xu_q;
        logic             xd_q;
        logic             up_e;
        logic             dn_e;
        logic [CNT_W-1:0] shadow;
        logic [CNT_W-1:0] active;
        logic [CNT_W-1:0] cmp;
        logic             pwm_r;

        assign up_e = ena && xu[k] && !xu_q;
        assign dn_e = ena && xd[k] && !xd_q;

`ifdef PWM_PHASE_STAGGER_EN
        localparam int OFF = k * (PERIOD / N_CH);
        logic [CNT_W:0] sum;
        assign sum = {1'b0, cnt} + (CNT_W+1)'(OFF);
        assign cmp = (sum >= (CNT_W+1)'(PERIOD)) ? CNT_W'(sum - (CNT_W+1)'(PERIOD))
                                                 : sum[CNT_W-1:0];
`else
        assign cmp = cnt;
`endif

        // While disabled, active tracks shadow so re-enable starts with current duty.
        always_ff @(posedge clk) begin
            if (rst) begin
                xu_q   <= 1'b0;
                xd_q   <= 1'b0;
                shadow <= DINIT;
                active <= DINIT;
                pwm_r  <= 1'b0;
            end else begin
                xu_q   <= xu[k];
                xd_q   <= xd[k];
                shadow <= CNT_W'(sat_add_sub(int'(shadow), up_e, dn_e, STEP, PERIOD));
                if (!ena || wrap) begin
                    active <= shadow;
                end
                pwm_r  <= ena && (cmp < active);
            end
        end

        assign pwm[k]                   = pwm_r;
        assign duty[k*CNT_W +: CNT_W]   = active;
    end

endmodule
